// File: rtl/sinegen_sweep_ctrl.sv
// rtl/sinegen_sweep_ctrl.sv - up/down phase-increment sweep sequencer for sinegen (optional SWEEP_PHASE_STEP_EN)
module sinegen_sweep_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DWELL_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     continuous,
   input  logic [DATA_WIDTH-1:0]    incr_min,
   input  logic [DATA_WIDTH-1:0]    incr_max,
   input  logic [DATA_WIDTH-1:0]    step,
   input  logic [DWELL_WIDTH-1:0]   dwell,
   input  logic [ADDRESS_WIDTH-1:0] offset_cfg,
`ifdef SWEEP_PHASE_STEP_EN
   input  logic [ADDRESS_WIDTH-1:0] offset_step,
`endif
   output logic                     en_out,
   output logic [DATA_WIDTH-1:0]    incr_out,
   output logic [ADDRESS_WIDTH-1:0] offset_out,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic                     cont_q, cont_d;
   logic [DATA_WIDTH-1:0]    min_q, min_d;
   logic [DATA_WIDTH-1:0]    max_q, max_d;
   logic [DATA_WIDTH-1:0]    step_q, step_d;
   logic [DATA_WIDTH-1:0]    incr_q, incr_d;
   logic [DWELL_WIDTH-1:0]   last_q, last_d;
   logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] ofs_q, ofs_d;
   logic                     en_q, en_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
`ifdef SWEEP_PHASE_STEP_EN
   logic [ADDRESS_WIDTH-1:0] ostep_q, ostep_d;
`endif
   logic                     boundary;

   // a + b saturated at ceil; the extra sum bit keeps the compare honest near full scale
   function automatic logic [DATA_WIDTH-1:0] add_clamp(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [DATA_WIDTH-1:0] ceil
   );
      logic [DATA_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, ceil}) begin
         add_clamp = ceil;
      end else begin
         add_clamp = sum[DATA_WIDTH-1:0];
      end
   endfunction

   // a - b floored at floor; the headroom is tested before subtracting so nothing underflows
   function automatic logic [DATA_WIDTH-1:0] sub_clamp(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [DATA_WIDTH-1:0] floor
   );
      if (a <= floor) begin
         sub_clamp = floor;
      end else if ((a - floor) <= b) begin
         sub_clamp = floor;
      end else begin
         sub_clamp = a - b;
      end
   endfunction

   // last_q holds dwell-1, so a level ends when the counter reaches it
   assign boundary = (cnt_q == last_q);

   // next-state, latched configuration and output values
   always_comb begin
      state_d = state_q;
      cont_d  = cont_q;
      min_d   = min_q;
      max_d   = max_q;
      step_d  = step_q;
      incr_d  = incr_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ofs_d   = ofs_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef SWEEP_PHASE_STEP_EN
      ostep_d = ostep_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            // stop in the same cycle suppresses the start entirely
            if (start && !stop) begin
               if (incr_min <= incr_max) begin
                  state_d = ST_UP;
                  cont_d  = continuous;
                  min_d   = incr_min;
                  max_d   = incr_max;
                  step_d  = (step == '0) ? DATA_WIDTH'(1) : step;
                  last_d  = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
                  incr_d  = incr_min;
                  ofs_d   = offset_cfg;
                  cnt_d   = '0;
                  en_d    = 1'b1;
                  busy_d  = 1'b1;
`ifdef SWEEP_PHASE_STEP_EN
                  ostep_d = offset_step;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_UP, ST_DOWN: begin
            if (stop) begin
               state_d = ST_IDLE;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (boundary) begin
               cnt_d = '0;
`ifdef SWEEP_PHASE_STEP_EN
               ofs_d = ofs_q + ostep_q;
`endif
               if (state_q == ST_UP) begin
                  if (incr_q == max_q) begin
                     state_d = ST_DOWN;
                     incr_d  = sub_clamp(max_q, step_q, min_q);
                  end else begin
                     incr_d = add_clamp(incr_q, step_q, max_q);
                  end
               end else begin
                  if (incr_q == min_q) begin
                     if (cont_q) begin
                        state_d = ST_UP;
                        incr_d  = add_clamp(min_q, step_q, max_q);
                     end else begin
                        // single-shot end: incr_out keeps its final level
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     incr_d = sub_clamp(incr_q, step_q, min_q);
                  end
               end
            end else begin
               cnt_d = cnt_q + DWELL_WIDTH'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cont_q  <= 1'b0;
         min_q   <= '0;
         max_q   <= '0;
         step_q  <= '0;
         incr_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         ofs_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef SWEEP_PHASE_STEP_EN
         ostep_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cont_q  <= cont_d;
         min_q   <= min_d;
         max_q   <= max_d;
         step_q  <= step_d;
         incr_q  <= incr_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ofs_q   <= ofs_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef SWEEP_PHASE_STEP_EN
         ostep_q <= ostep_d;
`endif
      end
   end

   assign en_out     = en_q;
   assign incr_out   = incr_q;
   assign offset_out = ofs_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_sinegen_sweep_ctrl.sv
// tb/tb_sinegen_sweep_ctrl.sv - self-checking bench for sinegen_sweep_ctrl
module tb_sinegen_sweep_ctrl;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int WW = 16;
`ifdef SWEEP_PHASE_STEP_EN
   localparam int OSTEP_ON = 1;
`else
   localparam int OSTEP_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          continuous = 1'b0;
   logic [DW-1:0] incr_min = '0;
   logic [DW-1:0] incr_max = '0;
   logic [DW-1:0] step = '0;
   logic [WW-1:0] dwell = '0;
   logic [AW-1:0] offset_cfg = '0;
`ifdef SWEEP_PHASE_STEP_EN
   logic [AW-1:0] offset_step = '0;
`endif
   logic          en_out;
   logic [DW-1:0] incr_out;
   logic [AW-1:0] offset_out;
   logic          busy;
   logic          done;
   logic          cfg_err;

   int errors = 0;
   int checks = 0;
   int lv[$];

   typedef struct {
      int mn;
      int mx;
      int st;
      int dw;
      int cont;
      int ofs;
      int ostep;
      int stop_at;
      int exp_en;
      int exp_done;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   sinegen_sweep_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .DWELL_WIDTH   (WW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .continuous  (continuous),
      .incr_min    (incr_min),
      .incr_max    (incr_max),
      .step        (step),
      .dwell       (dwell),
      .offset_cfg  (offset_cfg),
`ifdef SWEEP_PHASE_STEP_EN
      .offset_step (offset_step),
`endif
      .en_out      (en_out),
      .incr_out    (incr_out),
      .offset_out  (offset_out),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // list of levels visited: climb min..max in clamped steps, fall back to min, repeat if continuous
   function automatic void build_levels(input int mn, input int mx, input int s, input int cont, input int cap);
      int v;
      int pass;
      lv.delete();
      pass = 0;
      while (lv.size() < cap) begin
         v = (pass == 0) ? mn : ((mn + s > mx) ? mx : mn + s);
         while (1) begin
            lv.push_back(v);
            if (v == mx) break;
            v = (v + s > mx) ? mx : v + s;
         end
         v = (mx - s < mn) ? mn : mx - s;
         while (1) begin
            lv.push_back(v);
            if (v == mn) break;
            v = (v - s < mn) ? mn : v - s;
         end
         if (cont == 0) break;
         pass++;
      end
   endfunction

   function automatic int exp_ofs(input int ofs, input int ostep, input int nb);
      return (ofs + OSTEP_ON * ostep * nb) % 256;
   endfunction

   task automatic scramble_cfg();
      incr_min   = DW'($urandom);
      incr_max   = DW'($urandom);
      step       = DW'($urandom);
      dwell      = WW'($urandom_range(0, 5));
      continuous = 1'($urandom_range(0, 1));
      offset_cfg = AW'($urandom);
`ifdef SWEEP_PHASE_STEP_EN
      offset_step = AW'($urandom);
`endif
   endtask

   // runs one sweep, comparing every cycle with the level list; config is scrambled while busy
   task automatic run_sweep(input vec_t v, output int en_cnt, output int done_cnt);
      int d;
      int s;
      int total;
      int busy_len;
      int idx;
      int nb;
      int exp_done;
      bit stopped;
      d = (v.dw == 0) ? 1 : v.dw;
      s = (v.st == 0) ? 1 : v.st;
      build_levels(v.mn, v.mx, s, v.cont, 400);
      total    = lv.size() * d;
      stopped  = (v.stop_at != 0) && (v.stop_at < total);
      busy_len = stopped ? v.stop_at : total;
      en_cnt   = 0;
      done_cnt = 0;
      incr_min   = DW'(v.mn);
      incr_max   = DW'(v.mx);
      step       = DW'(v.st);
      dwell      = WW'(v.dw);
      continuous = (v.cont != 0);
      offset_cfg = AW'(v.ofs);
`ifdef SWEEP_PHASE_STEP_EN
      offset_step = AW'(v.ostep);
`endif
      start = 1'b1;
      stop  = 1'b0;
      tick();
      for (int k = 1; k <= busy_len + 2; k++) begin
         if (k <= busy_len) begin
            idx      = (k - 1) / d;
            nb       = idx;
            exp_done = 0;
         end else begin
            idx      = (busy_len - 1) / d;
            nb       = stopped ? idx : lv.size();
            exp_done = (k == busy_len + 1 && !stopped) ? 1 : 0;
         end
         check("incr_out", int'(incr_out), lv[idx]);
         check("offset_out", int'(offset_out), exp_ofs(v.ofs, v.ostep, nb));
         check("en_out", int'(en_out), (k <= busy_len) ? 1 : 0);
         check("busy", int'(busy), (k <= busy_len) ? 1 : 0);
         check("done", int'(done), exp_done);
         check("cfg_err", int'(cfg_err), 0);
         en_cnt   += int'(en_out);
         done_cnt += int'(done);
         if (k < busy_len) begin
            scramble_cfg();
            start = 1'($urandom_range(0, 1));
            stop  = 1'b0;
         end else if (k == busy_len) begin
            start = stopped;
            stop  = stopped;
         end else begin
            start = 1'b0;
            stop  = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      int en_cnt;
      int done_cnt;
      vec_t rv;

      //          mn   mx   st  dw cont ofs ostep stop en  done
      tbl[0] = '{  2,   6,   2,  3, 0,    7,  0,   0,  15, 1};
      tbl[1] = '{  1,   7,   4,  1, 1,    3,  0,  12,  12, 0};
      tbl[2] = '{  2,   6,   2,  3, 0,    7,  0,   5,   5, 0};
      tbl[3] = '{  4,   4,   0,  0, 0,    0,  0,   0,   2, 1};
      tbl[4] = '{  0, 255, 100,  2, 0,    1,  0,   0,  14, 1};
      tbl[5] = '{250, 255,   3,  1, 0,    9,  0,   0,   5, 1};
      tbl[6] = '{  1,   3,   1,  2, 0,  250, 10,   0,  10, 1};

      rst = 1'b0;
      repeat (2) tick();
      check("rst_en", int'(en_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_incr", int'(incr_out), 0);
      check("rst_offset", int'(offset_out), 0);
      check("rst_done", int'(done), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      rst = 1'b1;
      tick();

      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("idle_stop_en", int'(en_out), 0);
      check("idle_stop_busy", int'(busy), 0);

      incr_min = DW'(9);
      incr_max = DW'(3);
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("bad_cfg_err", int'(cfg_err), 1);
      check("bad_cfg_busy", int'(busy), 0);
      check("bad_cfg_en", int'(en_out), 0);
      tick();
      check("bad_cfg_err_clear", int'(cfg_err), 0);
      check("bad_cfg_busy2", int'(busy), 0);

      for (int i = 0; i < 7; i++) begin
         run_sweep(tbl[i], en_cnt, done_cnt);
         check($sformatf("tbl%0d_en_cycles", i), en_cnt, tbl[i].exp_en);
         check($sformatf("tbl%0d_done_count", i), done_cnt, tbl[i].exp_done);
      end

      incr_min   = DW'(2);
      incr_max   = DW'(6);
      step       = DW'(2);
      dwell      = WW'(3);
      continuous = 1'b0;
      offset_cfg = AW'(5);
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("pre_rst_en", int'(en_out), 1);
      rst = 1'b0;
      #1;
      check("async_rst_en", int'(en_out), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_incr", int'(incr_out), 0);
      check("async_rst_offset", int'(offset_out), 0);
      #2;
      rst = 1'b1;
      repeat (3) tick();
      check("post_rst_en", int'(en_out), 0);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_done", int'(done), 0);

      for (int r = 0; r < 10; r++) begin
         rv.mn    = int'($urandom_range(255, 0));
         rv.mx    = int'($urandom_range(255, rv.mn));
         rv.st    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(80, 1));
         rv.dw    = int'($urandom_range(3, 0));
         rv.cont  = int'($urandom_range(1, 0));
         rv.ofs   = int'($urandom_range(255, 0));
         rv.ostep = int'($urandom_range(255, 0));
         if (rv.cont != 0) begin
            rv.stop_at = int'($urandom_range(40, 1));
         end else begin
            rv.stop_at = ($urandom_range(1, 0) == 1) ? int'($urandom_range(12, 1)) : 0;
         end
         rv.exp_en   = 0;
         rv.exp_done = 0;
         run_sweep(rv, en_cnt, done_cnt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sinegen_sweep_ctrl.md
Name: sinegen_sweep_ctrl

Overview:
- Frequency-sweep sequencer that drives the `en`, `incr` and `offset` inputs of the sine generator.
- Steps the phase increment from a minimum to a maximum and back in programmable steps, holding each level for a programmable dwell.
- Supports single-shot or continuous sweeps.
- Sits between the top-level/config registers and the sinegen instance.

Parameters:
- DATA_WIDTH, 8, width of increment/step values (matches sinegen `incr`)
- ADDRESS_WIDTH, 8, width of phase offset (matches sinegen `offset`)
- DWELL_WIDTH, 16, width of dwell counter and `dwell` config

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep
- stop  in  1  single-cycle abort request
- continuous  in  1  1 = repeat up/down forever; 0 = one up/down pass
- incr_min  in  DATA_WIDTH  lowest increment
- incr_max  in  DATA_WIDTH  highest increment
- step  in  DATA_WIDTH  increment change per level
- dwell  in  DWELL_WIDTH  cycles each level is held
- offset_cfg  in  ADDRESS_WIDTH  phase offset for the second sine output
- en_out  out  1  to sinegen `en`
- incr_out  out  DATA_WIDTH  to sinegen `incr`
- offset_out  out  ADDRESS_WIDTH  to sinegen `offset`
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse at end of a single-shot sweep
- cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; dwell counter 0.
- States: IDLE, UP, DOWN.
- Config latch: `continuous`, `incr_min`, `incr_max`, `step`, `dwell` and `offset_cfg` are latched only on an accepted start. Changes while busy have no effect.
- Effective value corrections:
  - dwell=0 treated as 1.
  - step=0 treated as 1.
- Start acceptance: start in IDLE with incr_min<=incr_max. Next cycle:
  - state UP, busy=1, en_out=1
  - incr_out=incr_min, offset_out=offset_cfg
  - dwell counter=0
- Start rejection: start in IDLE with incr_min>incr_max. Stay in IDLE; cfg_err pulses next cycle.
- start while busy is ignored.
- Dwell: counter increments every cycle in UP/DOWN. At count == dwell-1 it is a level boundary: counter clears and the action below is taken. Each level is therefore held exactly dwell cycles.
- UP boundary:
  - If incr_out == max: go to DOWN, incr_out = max(incr_max-step, incr_min).
  - Otherwise: incr_out = min(incr_out+step, incr_max).
- DOWN boundary:
  - If incr_out == min and continuous=1: go to UP, incr_out = min(incr_min+step, incr_max).
  - If incr_out == min and continuous=0: go to IDLE; en_out=0, busy=0; done pulses one cycle; incr_out holds its last value.
  - Otherwise: incr_out = max(incr_out-step, incr_min), computed without underflow.
- Arithmetic: additions use DATA_WIDTH+1 bits and clamp, so the result never wraps.
- incr_min == incr_max: one dwell in UP, one dwell in DOWN, then end (or repeat).
- stop: in UP/DOWN, the next cycle goes to IDLE with en_out=0, busy=0 and no done pulse. In IDLE, stop has no effect.
- stop and start in the same cycle: stop wins and start is ignored.
- Latency: all outputs are registered; one cycle from start to en_out.

Optional Feature:
- Macro: SWEEP_PHASE_STEP_EN.
- When defined:
  - Adds input port `offset_step` (ADDRESS_WIDTH), latched at start.
  - offset_out increases by offset_step (modulo 2^ADDRESS_WIDTH, wraps) at every level boundary.
  - Resets to offset_cfg on each accepted start.
- When undefined: port absent; offset_out is constant at the latched offset_cfg while busy.

Test Plan:
- Reset mid-sweep: assert rst low during UP -> all outputs 0 immediately (async); after release stays IDLE until start.
- Single-shot, min=2, max=6, step=2, dwell=3, continuous=0:
  - incr_out sequence 2,4,6,4,2, each held 3 cycles (15 cycles en_out=1).
  - done pulses once; en_out=0 in the following cycle.
- Clamp, min=1, max=7, step=4, dwell=1, continuous=1 -> incr_out sequence 1,5,7,3,1,5,7,... with no wrap.
- Abort: stop asserted on cycle 5 of the single-shot case above -> en_out=0, busy=0 next cycle; done never pulses.
- Illegal config, min=9, max=3 -> cfg_err one-cycle pulse; busy stays 0. Same-cycle start+stop while busy -> stop wins.
- Edge values:
  - dwell=0, step=0, min=max=4 -> each level held 1 cycle; incr_out 4,4, then done.
  - With SWEEP_PHASE_STEP_EN, offset_cfg=250, offset_step=10 -> offset_out 250, then 4 after the first boundary (wrap).
